// File: rtl/miter_checker_if.sv
// Purpose: bundles the miter checker's run control, sample stream and status signals.
// Latency: none, wiring only.
// Backpressure: in_valid/in_ready handshake; a sample transfers when both are high.
// The first_a/first_b capture outputs exist only when MITER_CHECKER_CAPTURE_EN is defined.
interface miter_checker_if #(
    parameter int CNT_W = 32,
    parameter int CAP_W = 16
);
    // Run control
    logic             start;
    logic             stop_on_fail;
    logic [CNT_W-1:0] num_samples;
    // Sample stream
    logic             in_valid;
    logic             in_ready;
    logic             result;
    logic             condition;
    logic [3:0]       control;
    logic [CAP_W-1:0] a_lo;
    logic [CAP_W-1:0] b_lo;
    // Status
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] checked_cnt;
    logic [CNT_W-1:0] skipped_cnt;
    logic [CNT_W-1:0] viol_cnt;
    logic [3:0]       first_ctrl;
`ifdef MITER_CHECKER_CAPTURE_EN
    logic [CAP_W-1:0] first_a;
    logic [CAP_W-1:0] first_b;

    modport master (
        output start, stop_on_fail, num_samples, in_valid, result, condition, control, a_lo, b_lo,
        input  in_ready, busy, done, pass, checked_cnt, skipped_cnt, viol_cnt, first_ctrl,
               first_a, first_b
    );
    modport slave (
        input  start, stop_on_fail, num_samples, in_valid, result, condition, control, a_lo, b_lo,
        output in_ready, busy, done, pass, checked_cnt, skipped_cnt, viol_cnt, first_ctrl,
               first_a, first_b
    );
`else
    modport master (
        output start, stop_on_fail, num_samples, in_valid, result, condition, control, a_lo, b_lo,
        input  in_ready, busy, done, pass, checked_cnt, skipped_cnt, viol_cnt, first_ctrl
    );
    modport slave (
        input  start, stop_on_fail, num_samples, in_valid, result, condition, control, a_lo, b_lo,
        output in_ready, busy, done, pass, checked_cnt, skipped_cnt, viol_cnt, first_ctrl
    );
`endif
endinterface

// File: rtl/miter_checker.sv
// Purpose: counts checked/skipped/violating alu_miter samples over a run of num_samples accepts.
// Latency: counters/latches update the cycle after an accept; done pulses the cycle after the last accept.
// Backpressure: in_ready is high for the whole RUN state only; samples outside RUN are never consumed.
// Optional macro MITER_CHECKER_CAPTURE_EN adds first_a/first_b operand captures of the first violation.
module miter_checker #(
    parameter int CNT_W = 32,
    parameter int CAP_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    miter_checker_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic             stop_q, stop_d;
    logic [CNT_W-1:0] chk_q, chk_d;
    logic [CNT_W-1:0] skip_q, skip_d;
    logic [CNT_W-1:0] viol_q, viol_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic             pass_q, pass_d;
`ifdef MITER_CHECKER_CAPTURE_EN
    logic [CAP_W-1:0] first_a_q, first_a_d;
    logic [CAP_W-1:0] first_b_q, first_b_d;
`else
    logic [2*CAP_W-1:0] unused_caps;
    assign unused_caps = {bus.a_lo, bus.b_lo};
`endif

    logic start_ok;
    logic accept;
    logic viol_hit;
    logic last_hit;

    assign start_ok = bus.start && (state_q != S_RUN);
    assign accept   = bus.in_valid && (state_q == S_RUN);
    assign viol_hit = accept && bus.condition && bus.result;
    // acc_q never exceeds num_q - 1 while running, so this compare cannot be fooled by wrap
    assign last_hit = accept && (acc_q == (num_q - CNT_W'(1)));

    // Next-state logic: run sequencing, saturating counters and first-violation latch
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        acc_d   = acc_q;
        stop_d  = stop_q;
        chk_d   = chk_q;
        skip_d  = skip_q;
        viol_d  = viol_q;
        ctrl_d  = ctrl_q;
        pass_d  = pass_q;
`ifdef MITER_CHECKER_CAPTURE_EN
        first_a_d = first_a_q;
        first_b_d = first_b_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    num_d   = bus.num_samples;
                    stop_d  = bus.stop_on_fail;
                    acc_d   = '0;
                    chk_d   = '0;
                    skip_d  = '0;
                    viol_d  = '0;
                    ctrl_d  = '0;
                    pass_d  = 1'b0;  // a zero-length run lands in DONE with nothing checked
`ifdef MITER_CHECKER_CAPTURE_EN
                    first_a_d = '0;
                    first_b_d = '0;
`endif
                    state_d = (bus.num_samples != '0) ? S_RUN : S_DONE;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (accept) begin
                    acc_d = acc_q + CNT_W'(1);
                    if (bus.condition) begin
                        if (chk_q != '1) chk_d = chk_q + CNT_W'(1);
                    end else begin
                        if (skip_q != '1) skip_d = skip_q + CNT_W'(1);
                    end
                    if (viol_hit) begin
                        if (viol_q != '1) viol_d = viol_q + CNT_W'(1);
                        // viol_q saturates rather than wraps, so zero means no violation yet
                        if (viol_q == '0) begin
                            ctrl_d = bus.control;
`ifdef MITER_CHECKER_CAPTURE_EN
                            first_a_d = bus.a_lo;
                            first_b_d = bus.b_lo;
`endif
                        end
                    end
                    if (last_hit || (stop_q && viol_hit)) begin
                        state_d = S_DONE;
                        pass_d  = (chk_d != '0) && (viol_d == '0);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers, cleared asynchronously so a reset mid-run drops the run silently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            num_q   <= '0;
            acc_q   <= '0;
            stop_q  <= 1'b0;
            chk_q   <= '0;
            skip_q  <= '0;
            viol_q  <= '0;
            ctrl_q  <= '0;
            pass_q  <= 1'b0;
`ifdef MITER_CHECKER_CAPTURE_EN
            first_a_q <= '0;
            first_b_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            acc_q   <= acc_d;
            stop_q  <= stop_d;
            chk_q   <= chk_d;
            skip_q  <= skip_d;
            viol_q  <= viol_d;
            ctrl_q  <= ctrl_d;
            pass_q  <= pass_d;
`ifdef MITER_CHECKER_CAPTURE_EN
            first_a_q <= first_a_d;
            first_b_q <= first_b_d;
`endif
        end
    end

    assign bus.in_ready    = (state_q == S_RUN);
    assign bus.busy        = (state_q == S_RUN);
    assign bus.done        = (state_q == S_DONE);
    assign bus.pass        = pass_q;
    assign bus.checked_cnt = chk_q;
    assign bus.skipped_cnt = skip_q;
    assign bus.viol_cnt    = viol_q;
    assign bus.first_ctrl  = ctrl_q;
`ifdef MITER_CHECKER_CAPTURE_EN
    assign bus.first_a     = first_a_q;
    assign bus.first_b     = first_b_q;
`endif
endmodule

// File: tb/tb_miter_checker.sv
// Purpose: self-checking bench for miter_checker, directed scenarios plus randomized runs.
// Latency: checks done one cycle after the terminating accept.
// Backpressure: in_valid is driven with random gaps; acceptance is predicted from the run model.
module tb_miter_checker;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    miter_checker_if #(.CNT_W(32), .CAP_W(16)) bus ();

    miter_checker #(.CNT_W(32), .CAP_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit        cond;
        bit        res;
        logic [3:0]  ctrl;
        logic [15:0] a;
        logic [15:0] b;
    } samp_t;

    samp_t samp_q[$];

    // Expectations produced by the run model
    int          exp_chk, exp_skip, exp_viol;
    logic [3:0]  exp_ctrl;
    logic [15:0] exp_a, exp_b;
    bit          exp_pass;
    bit          proto_ok;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit c, input bit r, input logic [3:0] ctl, input logic [15:0] a,
                        input logic [15:0] b);
        samp_t s;
        s.cond = c; s.res = r; s.ctrl = ctl; s.a = a; s.b = b;
        samp_q.push_back(s);
    endtask

    task automatic idle_inputs();
        bus.start = 0; bus.stop_on_fail = 0; bus.num_samples = 0; bus.in_valid = 0;
        bus.result = 0; bus.condition = 0; bus.control = 0; bus.a_lo = 0; bus.b_lo = 0;
    endtask

    // Launches a run and feeds samp_q; the model decides which cycles are accepted
    // (every valid cycle between start and the end of the run) and what the run ends with.
    task automatic drive_run(input int num, input bit stop, input bit gaps);
        int  n_acc;
        int  cycles;
        bit  fin;
        bit  v;
        bit  seen_viol;
        samp_t s;
        exp_chk = 0; exp_skip = 0; exp_viol = 0; exp_ctrl = 0; exp_a = 0; exp_b = 0;
        proto_ok = 1; n_acc = 0; cycles = 0; seen_viol = 0;
        bus.start = 1; bus.num_samples = num; bus.stop_on_fail = stop; bus.in_valid = 0;
        step();
        bus.start = 0;
        bus.stop_on_fail = ~stop;  // must have been captured at start
        fin = (num == 0);
        while (!fin && cycles < 2000) begin
            if (bus.in_ready !== 1'b1 || bus.busy !== 1'b1 || bus.done !== 1'b0) proto_ok = 0;
            v = (samp_q.size() != 0) && (!gaps || $urandom_range(0, 3) != 0);
            if (v) begin
                s = samp_q.pop_front();
                bus.in_valid = 1; bus.condition = s.cond; bus.result = s.res;
                bus.control = s.ctrl; bus.a_lo = s.a; bus.b_lo = s.b;
            end else begin
                bus.in_valid = 0; bus.condition = 1; bus.result = 1;
                bus.control = 4'($urandom); bus.a_lo = 16'($urandom); bus.b_lo = 16'($urandom);
            end
            step();
            cycles++;
            if (v) begin
                n_acc++;
                if (s.cond) exp_chk++; else exp_skip++;
                if (s.cond && s.res) begin
                    exp_viol++;
                    if (!seen_viol) begin
                        seen_viol = 1; exp_ctrl = s.ctrl; exp_a = s.a; exp_b = s.b;
                    end
                end
                if (n_acc == num || (stop && s.cond && s.res)) fin = 1;
            end
        end
        bus.in_valid = 0;
        if (!fin) proto_ok = 0;
        if (bus.done !== 1'b1 || bus.in_ready !== 1'b0 || bus.busy !== 1'b0) proto_ok = 0;
        exp_pass = (exp_chk > 0) && (exp_viol == 0);
        samp_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        #3;
        checks++;
        if ({bus.in_ready, bus.busy, bus.done, bus.pass} !== 4'b0000 || bus.checked_cnt !== 0 ||
            bus.skipped_cnt !== 0 || bus.viol_cnt !== 0 || bus.first_ctrl !== 0) begin
            failures++;
            $display("FAIL reset_state: rdy/busy/done/pass=%b chk=%0d skp=%0d vio=%0d ctrl=%0d want all 0",
                     {bus.in_ready, bus.busy, bus.done, bus.pass}, bus.checked_cnt,
                     bus.skipped_cnt, bus.viol_cnt, bus.first_ctrl);
        end
        step(); step();
        rst_n = 1;
        step();
        // samples offered while idle must be ignored
        bus.in_valid = 1; bus.condition = 1; bus.result = 1; bus.control = 4'hA;
        repeat (3) step();
        bus.in_valid = 0;
        checks++;
        if (bus.in_ready !== 0 || bus.checked_cnt !== 0 || bus.viol_cnt !== 0 || bus.first_ctrl !== 0) begin
            failures++;
            $display("FAIL idle_ignores_valid: rdy=%b chk=%0d vio=%0d ctrl=%0d want 0",
                     bus.in_ready, bus.checked_cnt, bus.viol_cnt, bus.first_ctrl);
        end
    endtask

    task automatic test_basic();
        repeat (4) push(1, 0, 4'h1, 16'h0, 16'h0);
        drive_run(4, 0, 0);
        checks++;
        if (!proto_ok) begin
            failures++; $display("FAIL basic_proto: handshake/done timing wrong, got ok=%0b want 1", proto_ok);
        end
        checks++;
        if (bus.pass !== 1'b1 || bus.checked_cnt !== 4 || bus.viol_cnt !== 0 || bus.skipped_cnt !== 0) begin
            failures++;
            $display("FAIL basic_counts: pass=%b chk=%0d vio=%0d skp=%0d want 1/4/0/0",
                     bus.pass, bus.checked_cnt, bus.viol_cnt, bus.skipped_cnt);
        end
        step();
        checks++;
        if (bus.done !== 1'b0 || bus.pass !== 1'b1 || bus.checked_cnt !== 4) begin
            failures++;
            $display("FAIL basic_done_pulse: done=%b pass=%b chk=%0d want 0/1/4",
                     bus.done, bus.pass, bus.checked_cnt);
        end
    endtask

    task automatic test_mixed();
        push(1, 0, 4'h1, 0, 0); push(0, 1, 4'h2, 0, 0); push(1, 1, 4'h8, 0, 0);
        push(1, 1, 4'h3, 0, 0); push(1, 0, 4'h4, 0, 0);
        drive_run(5, 0, 1);
        checks++;
        if (!proto_ok || bus.checked_cnt !== 4 || bus.skipped_cnt !== 1 || bus.viol_cnt !== 2 ||
            bus.first_ctrl !== 4'h8 || bus.pass !== 1'b0) begin
            failures++;
            $display("FAIL mixed_run: ok=%0b chk=%0d skp=%0d vio=%0d ctrl=%0d pass=%b want 1/4/1/2/8/0",
                     proto_ok, bus.checked_cnt, bus.skipped_cnt, bus.viol_cnt, bus.first_ctrl, bus.pass);
        end
    endtask

    task automatic test_stop_on_fail();
        push(1, 0, 4'h1, 0, 0); push(1, 0, 4'h2, 0, 0); push(1, 1, 4'h6, 0, 0);
        for (int i = 0; i < 7; i++) push(1, 0, 4'h7, 0, 0);
        drive_run(10, 1, 0);
        checks++;
        if (!proto_ok || bus.in_ready !== 0 || bus.checked_cnt !== 3 || bus.viol_cnt !== 1 ||
            bus.first_ctrl !== 4'h6) begin
            failures++;
            $display("FAIL stop_on_fail: ok=%0b rdy=%b chk=%0d vio=%0d ctrl=%0d want 1/0/3/1/6",
                     proto_ok, bus.in_ready, bus.checked_cnt, bus.viol_cnt, bus.first_ctrl);
        end
    endtask

    task automatic test_zero_len();
        // preceded by a passing run so pass must actively clear
        push(1, 0, 4'h1, 0, 0);
        drive_run(1, 0, 0);
        checks++;
        if (bus.pass !== 1'b1) begin
            failures++; $display("FAIL zero_len_setup_pass: pass=%b want 1", bus.pass);
        end
        drive_run(0, 0, 0);
        checks++;
        if (!proto_ok || bus.pass !== 0 || bus.checked_cnt !== 0 || bus.skipped_cnt !== 0 ||
            bus.viol_cnt !== 0) begin
            failures++;
            $display("FAIL zero_len: ok=%0b pass=%b chk=%0d skp=%0d vio=%0d want 1/0/0/0/0",
                     proto_ok, bus.pass, bus.checked_cnt, bus.skipped_cnt, bus.viol_cnt);
        end
    endtask

    task automatic test_start_in_run();
        bit saw_done;
        bus.start = 1; bus.num_samples = 3; bus.stop_on_fail = 0;
        step();
        bus.start = 0;
        bus.in_valid = 1; bus.condition = 1; bus.result = 0; bus.control = 4'h1;
        step();
        // start while running must neither restart nor change the length
        bus.start = 1; bus.num_samples = 1; bus.result = 1; bus.control = 4'h5;
        step();
        bus.start = 0; bus.result = 0; bus.control = 4'h2;
        checks++;
        if (bus.done !== 0 || bus.checked_cnt !== 2) begin
            failures++;
            $display("FAIL start_in_run_mid: done=%b chk=%0d want 0/2", bus.done, bus.checked_cnt);
        end
        step();
        bus.in_valid = 0;
        saw_done = bus.done;
        checks++;
        if (saw_done !== 1'b1 || bus.checked_cnt !== 3 || bus.viol_cnt !== 1 || bus.first_ctrl !== 4'h5) begin
            failures++;
            $display("FAIL start_in_run_end: done=%b chk=%0d vio=%0d ctrl=%0d want 1/3/1/5",
                     saw_done, bus.checked_cnt, bus.viol_cnt, bus.first_ctrl);
        end
        step();
    endtask

    task automatic test_reset_mid_run();
        int done_seen;
        done_seen = 0;
        bus.start = 1; bus.num_samples = 6; bus.stop_on_fail = 0;
        step();
        bus.start = 0;
        bus.in_valid = 1; bus.condition = 1; bus.result = 1; bus.control = 4'h9;
        repeat (2) step();
        bus.in_valid = 0;
        rst_n = 0;
        #2;
        checks++;
        if (bus.checked_cnt !== 0 || bus.viol_cnt !== 0 || bus.first_ctrl !== 0 ||
            bus.in_ready !== 0 || bus.busy !== 0 || bus.done !== 0) begin
            failures++;
            $display("FAIL reset_mid_run_clear: chk=%0d vio=%0d ctrl=%0d rdy=%b busy=%b done=%b want 0",
                     bus.checked_cnt, bus.viol_cnt, bus.first_ctrl, bus.in_ready, bus.busy, bus.done);
        end
        step();
        rst_n = 1;
        bus.in_valid = 1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.done !== 0 || bus.in_ready !== 0) done_seen++;
        end
        bus.in_valid = 0;
        checks++;
        if (done_seen != 0) begin
            failures++;
            $display("FAIL reset_mid_run_quiet: active cycles=%0d want 0", done_seen);
        end
        repeat (3) push(1, 0, 4'h1, 0, 0);
        drive_run(3, 0, 0);
        checks++;
        if (!proto_ok || bus.checked_cnt !== 3 || bus.pass !== 1) begin
            failures++;
            $display("FAIL reset_mid_run_rerun: ok=%0b chk=%0d pass=%b want 1/3/1",
                     proto_ok, bus.checked_cnt, bus.pass);
        end
    endtask

    task automatic test_random();
        int num;
        bit stop;
        for (int r = 0; r < 25; r++) begin
            num  = $urandom_range(1, 12);
            stop = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < num; i++)
                push($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, 4'($urandom),
                     16'($urandom), 16'($urandom));
            drive_run(num, stop, 1);
            checks++;
            if (!proto_ok || bus.checked_cnt !== exp_chk || bus.skipped_cnt !== exp_skip ||
                bus.viol_cnt !== exp_viol || bus.first_ctrl !== exp_ctrl || bus.pass !== exp_pass) begin
                failures++;
                $display("FAIL random_run%0d: ok=%0b chk=%0d/%0d skp=%0d/%0d vio=%0d/%0d ctrl=%0d/%0d pass=%b/%b (got/want)",
                         r, proto_ok, bus.checked_cnt, exp_chk, bus.skipped_cnt, exp_skip,
                         bus.viol_cnt, exp_viol, bus.first_ctrl, exp_ctrl, bus.pass, exp_pass);
            end
`ifdef MITER_CHECKER_CAPTURE_EN
            checks++;
            if (bus.first_a !== exp_a || bus.first_b !== exp_b) begin
                failures++;
                $display("FAIL random_capture%0d: a=%h/%h b=%h/%h (got/want)",
                         r, bus.first_a, exp_a, bus.first_b, exp_b);
            end
`endif
            // half the time restart straight from DONE, otherwise linger into IDLE
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) step();
        end
    endtask

`ifdef MITER_CHECKER_CAPTURE_EN
    task automatic test_capture();
        push(1, 0, 4'h1, 16'hAAAA, 16'hBBBB);
        push(1, 1, 4'h2, 16'h1234, 16'h00FF);
        push(1, 1, 4'h3, 16'h5555, 16'h6666);
        drive_run(3, 0, 0);
        checks++;
        if (bus.first_a !== 16'h1234 || bus.first_b !== 16'h00FF || bus.first_ctrl !== 4'h2) begin
            failures++;
            $display("FAIL capture: a=%h b=%h ctrl=%0d want 1234/00ff/2",
                     bus.first_a, bus.first_b, bus.first_ctrl);
        end
    endtask
`endif

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_mixed();
        test_stop_on_fail();
        test_zero_len();
        test_start_in_run();
        test_reset_mid_run();
`ifdef MITER_CHECKER_CAPTURE_EN
        test_capture();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/miter_checker.md
MITER_CHECKER -- requirements
Module: miter_checker

Interface
REQ-001 Parameter: CNT_W, 32, width of sample/event counters and num_samples.
REQ-002 Parameter: CAP_W, 16, width of captured operand slices.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle pulse launching a check run; honoured only in IDLE or DONE.
REQ-006 stop_on_fail  in  1  sampled at start; when 1, the run ends at the first violation.
REQ-007 num_samples  in  CNT_W  run length in accepted samples; sampled at start.
REQ-008 in_valid  in  1  miter sample present this cycle.
REQ-009 in_ready  out  1  checker accepts a sample this cycle.
REQ-010 result  in  1  alu_miter result bit (1 = outputs differ).
REQ-011 condition  in  1  alu_miter condition bit (1 = equivalence required).
REQ-012 control  in  4  ALU control code of the sample.
REQ-013 a_lo, b_lo  in  CAP_W each  low operand slices of the sample.
REQ-014 busy  out  1  run in progress.
REQ-015 done  out  1  one-cycle pulse at run end.
REQ-016 pass  out  1  last run completed with checked_cnt>0 and viol_cnt==0.
REQ-017 checked_cnt, skipped_cnt, viol_cnt  out  CNT_W each  saturating run counters.
REQ-018 first_ctrl  out  4  control of the first violation of the run.

Function
REQ-019 FSM states: IDLE, RUN, DONE; encoding is free.
REQ-020 Transitions: IDLE/DONE->RUN on start with num_samples!=0; IDLE/DONE->DONE on start with num_samples==0; RUN->DONE on the accept that makes the accepted-sample count equal num_samples, or on the first violating accept when stop_on_fail=1; DONE->IDLE after one cycle without start.
REQ-021 in_ready=1 exactly in RUN; busy=1 exactly in RUN; done=1 exactly in DONE.
REQ-022 Accept = in_valid & in_ready; no sample is consumed otherwise and in_valid in IDLE/DONE is ignored.
REQ-023 Per accept: condition=1 -> checked_cnt+1; condition=1 & result=1 -> viol_cnt+1; condition=0 -> skipped_cnt+1, with result ignored.
REQ-024 Counters saturate at all-ones; the accepted-sample count used for termination does not saturate below num_samples.
REQ-025 The first violation of a run latches first_ctrl; later violations leave it unchanged.
REQ-026 Latency: counter and latch updates are visible the cycle after the accept edge; done is asserted the cycle after the terminating accept.
REQ-027 start clears all counters, first_ctrl, pass and the captures on the same edge the run begins; start in RUN is ignored.
REQ-028 pass is updated on entry to DONE and holds until the next honoured start or reset.

Reset
REQ-029 rst_n=0 forces IDLE immediately; all counters, first_ctrl, captures, pass, done, busy and in_ready are 0.
REQ-030 Reset mid-run discards the run with no done pulse; the next run requires a new start.

Configuration
REQ-031 Macro MITER_CHECKER_CAPTURE_EN defined: outputs first_a and first_b (CAP_W each) latch a_lo and b_lo with first_ctrl under the same rules.
REQ-032 Macro undefined: first_a and first_b and their registers are absent; all other behaviour is identical.

Verification
REQ-033 start, num_samples=4, 4 accepts with condition=1, result=0 -> done one cycle after the 4th accept; pass=1, checked=4, viol=0.
REQ-034 num_samples=5, samples (cond,res)=(1,0),(0,1),(1,1) ctrl=8,(1,1) ctrl=3,(1,0) -> checked=4, skipped=1, viol=2, first_ctrl=8, pass=0.
REQ-035 stop_on_fail=1, num_samples=10, violation on the 3rd accept -> RUN->DONE, in_ready=0 the next cycle, checked=3.
REQ-036 start with num_samples=0 -> done on the following cycle; pass=0, all counters 0.
REQ-037 rst_n low for 1 cycle after 2 of 6 accepts -> counters 0, state IDLE, no done pulse; a new start runs normally.
REQ-038 Capture build, violation with a_lo=0x1234, b_lo=0x00FF -> first_a=0x1234, first_b=0x00FF; a second violation leaves both unchanged.
